// File: rtl/alu_ctrl_issue.sv
// ALU control decode and issue stage: registers operands and the decoded control code, then hands them downstream.
// Latency 1 cycle (MUL_CYCLES+1 for multiply); holds the result until ready_i, and accepts back-to-back in the hand-off cycle.
module alu_ctrl_issue #(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [9:0]  funct_i,
  input  logic [1:0]  aluOp_i,
  input  logic [31:0] rs1Data_i,
  input  logic [31:0] rs2Data_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [3:0]  aluCtrl_o,
  output logic [31:0] aluSrc1_o,
  output logic [31:0] aluSrc2_o,
  output logic        illegal_o
);

  localparam logic [3:0] MulCycles = 4'(MUL_CYCLES);
  localparam logic [3:0] CtrlMul   = 4'b0011;

  typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;

  state_t     state, stateNxt;
  logic [3:0] cnt;
  logic [3:0] decCtrl;
  logic       decLegal;
  logic       accept;
  logic       isMul;

  always_comb begin
    decCtrl  = 4'b0010;
    decLegal = 1'b1;
    case (aluOp_i)
      2'b11: decCtrl = 4'b0110;
      2'b10: begin
        case (funct_i)
          10'b0000000111: decCtrl = 4'b0000;
          10'b0000000110: decCtrl = 4'b0001;
          10'b0000000000: decCtrl = 4'b0010;
          10'b0100000000: decCtrl = 4'b0110;
          10'b0000001000: decCtrl = CtrlMul;
          default:        decLegal = 1'b0;
        endcase
      end
      default: decCtrl = 4'b0010;
    endcase
  end

  assign accept = valid_i & ready_o;
  assign isMul  = (decCtrl == CtrlMul);

  always_comb begin
    stateNxt = state;
    ready_o  = 1'b0;
    valid_o  = 1'b0;
    case (state)
      IDLE: ready_o = rst_i;
      WAIT: if (cnt == 4'd1) stateNxt = VALID;
      VALID: begin
        valid_o = 1'b1;
        ready_o = rst_i & ready_i;
        if (ready_i) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
    // A new request in the hand-off cycle overrides the return to IDLE.
    if (accept) begin
      if (!decLegal)                      stateNxt = IDLE;
      else if (isMul && MulCycles != 4'd0) stateNxt = WAIT;
      else                                stateNxt = VALID;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      aluCtrl_o <= 4'b0000;
      aluSrc1_o <= 32'd0;
      aluSrc2_o <= 32'd0;
      illegal_o <= 1'b0;
    end else begin
      state     <= stateNxt;
      illegal_o <= accept & ~decLegal;
      if (accept && decLegal) begin
        aluCtrl_o <= decCtrl;
        aluSrc1_o <= rs1Data_i;
        aluSrc2_o <= rs2Data_i;
        cnt       <= isMul ? MulCycles : 4'd0;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Bench for alu_ctrl_issue: directed scenarios with literal expectations, then randomized traffic against a cycle model.
module tb_alu_ctrl_issue;
  localparam int MUL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        validIn = 1'b0;
  logic        readyOut;
  logic [9:0]  funct = '0;
  logic [1:0]  aluOp = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        validOut;
  logic        readyIn = 1'b0;
  logic [3:0]  aluCtrl;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  // Model: at most one pending issued op, visible once its wait has elapsed.
  bit          pend = 1'b0;
  logic [3:0]  pCtrl = '0;
  logic [31:0] pS1 = '0;
  logic [31:0] pS2 = '0;
  int          waitLeft = 0;
  bit          expIll = 1'b0;
  logic [3:0]  lastCtrl = '0;

  always #5 clk = ~clk;

  alu_ctrl_issue #(.MUL_CYCLES(MUL)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(validIn), .ready_o(readyOut),
    .funct_i(funct), .aluOp_i(aluOp), .rs1Data_i(rs1), .rs2Data_i(rs2),
    .valid_o(validOut), .ready_i(readyIn), .aluCtrl_o(aluCtrl),
    .aluSrc1_o(src1), .aluSrc2_o(src2), .illegal_o(illegal)
  );

  function automatic int refDecode(logic [1:0] op, logic [9:0] f);
    if (op != 2'b10) return (op == 2'b11) ? 6 : 2;
    case (f)
      10'h007: return 0;
      10'h006: return 1;
      10'h000: return 2;
      10'h100: return 6;
      10'h008: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic bit expValid();
    return pend && (waitLeft == 0);
  endfunction

  function automatic bit expReady();
    return rst && (!pend || (expValid() && readyIn));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    check("valid_o", 32'(validOut), 32'(expValid()));
    check("ready_o", 32'(readyOut), 32'(expReady()));
    check("illegal_o", 32'(illegal), 32'(expIll));
    check("aluCtrl_o", 32'(aluCtrl), 32'(lastCtrl));
    if (expValid()) begin
      check("aluSrc1_o", src1, pS1);
      check("aluSrc2_o", src2, pS2);
    end
  endtask

  task automatic updateModel();
    bit acc;
    int code;
    if (!rst) begin
      pend = 0; waitLeft = 0; expIll = 0; lastCtrl = '0;
      return;
    end
    acc = validIn && expReady();
    code = refDecode(aluOp, funct);
    expIll = 0;
    if (expValid() && readyIn) pend = 0;
    else if (pend && waitLeft > 0) waitLeft--;
    if (acc) begin
      if (code < 0) expIll = 1;
      else begin
        pend = 1; pCtrl = 4'(code); pS1 = rs1; pS2 = rs2;
        lastCtrl = 4'(code);
        waitLeft = (code == 3) ? MUL : 0;
      end
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input logic [9:0] f,
                       input logic [31:0] a, input logic [31:0] b, input bit r, input bit rs);
    @(posedge clk);
    updateModel();
    @(negedge clk);
    validIn = v; aluOp = op; funct = f; rs1 = a; rs2 = b; readyIn = r; rst = rs;
    #1;
    compareModel();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 2'b00, 10'h0, 0, 0, 1, 1);
  endtask

  initial begin
    drive(0, 2'b00, 10'h0, 0, 0, 1, 0);
    check("rst valid", 32'(validOut), 0);
    check("rst ready", 32'(readyOut), 0);
    check("rst ctrl", 32'(aluCtrl), 0);
    check("rst src1", src1, 0);
    check("rst src2", src2, 0);
    drive(0, 2'b00, 10'h0, 0, 0, 1, 0);

    // add
    drive(1, 2'b10, 10'h000, 5, 7, 1, 1);
    check("add ready first", 32'(readyOut), 1);
    drive(0, 2'b00, 10'h0, 0, 0, 1, 1);
    check("add valid", 32'(validOut), 1);
    check("add ctrl", 32'(aluCtrl), 4'b0010);
    check("add src1", src1, 5);
    check("add src2", src2, 7);
    idle(1);
    check("add idle", 32'(validOut), 0);

    // multiply
    drive(1, 2'b10, 10'h008, 6, 9, 1, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b10, 10'h000, 1, 1, 1, 1);
      check("mul wait ready", 32'(readyOut), 0);
      check("mul wait valid", 32'(validOut), 0);
    end
    drive(0, 2'b00, 10'h0, 0, 0, 1, 1);
    check("mul valid", 32'(validOut), 1);
    check("mul ctrl", 32'(aluCtrl), 4'b0011);
    check("mul src1", src1, 6);
    check("mul src2", src2, 9);
    idle(1);

    // backpressure
    drive(1, 2'b10, 10'h100, 11, 3, 0, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'b10, 10'h007, 99, 98, 0, 1);
      check("bp valid", 32'(validOut), 1);
      check("bp ctrl", 32'(aluCtrl), 4'b0110);
      check("bp ready", 32'(readyOut), 0);
      check("bp src1", src1, 11);
    end
    drive(0, 2'b00, 10'h0, 0, 0, 1, 1);
    check("bp release ready", 32'(readyOut), 1);
    idle(1);
    check("bp idle", 32'(validOut), 0);

    // back-to-back and / or
    drive(1, 2'b10, 10'h007, 32'hF0, 32'h0F, 1, 1);
    drive(1, 2'b10, 10'h006, 32'hA0, 32'h0A, 1, 1);
    check("b2b and valid", 32'(validOut), 1);
    check("b2b and ctrl", 32'(aluCtrl), 4'b0000);
    drive(0, 2'b00, 10'h0, 0, 0, 1, 1);
    check("b2b or valid", 32'(validOut), 1);
    check("b2b or ctrl", 32'(aluCtrl), 4'b0001);
    check("b2b or src1", src1, 32'hA0);
    idle(1);
    check("b2b idle", 32'(validOut), 0);

    // illegal then aluOp 11
    drive(1, 2'b10, 10'h005, 1, 2, 1, 1);
    drive(1, 2'b11, 10'h3FF, 3, 4, 1, 1);
    check("ill pulse", 32'(illegal), 1);
    check("ill valid", 32'(validOut), 0);
    drive(0, 2'b00, 10'h0, 0, 0, 1, 1);
    check("ill pulse end", 32'(illegal), 0);
    check("op11 ctrl", 32'(aluCtrl), 4'b0110);
    check("op11 valid", 32'(validOut), 1);
    idle(1);

    // reset mid-multiply
    drive(1, 2'b10, 10'h008, 6, 9, 1, 1);
    drive(0, 2'b00, 10'h0, 0, 0, 1, 1);
    drive(0, 2'b00, 10'h0, 0, 0, 1, 0);
    check("mrst ready low", 32'(readyOut), 0);
    drive(0, 2'b00, 10'h0, 0, 0, 1, 1);
    check("mrst ctrl", 32'(aluCtrl), 0);
    check("mrst src1", src1, 0);
    check("mrst src2", src2, 0);
    check("mrst ready", 32'(readyOut), 1);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("mrst no valid", 32'(validOut), 0);
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [9:0] f;
      case ($urandom_range(0, 5))
        0: f = 10'h007;
        1: f = 10'h006;
        2: f = 10'h000;
        3: f = 10'h100;
        4: f = 10'h008;
        default: f = 10'($urandom);
      endcase
      drive($urandom_range(0, 2) != 0, 2'($urandom), f, $urandom, $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 99) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
